// File: rtl/spike_writeback_if.sv
// spike_writeback_if: handshake bundle between the SNN sum unit, spike_writeback and the spike memory.
//  in_valid/in_ready/in_data       result stream {spike, residual potential} into the writeback stage
//  mp_valid/mp_ready/mp_data       potential feedback packets {2'b00, potential} back to the sum unit
//  spk_valid/spk_ready/spk_data    packed spike row words, tagged with spk_row and spk_ts
//  done                            all timesteps complete
//  master = the writeback stage, slave = its environment
interface spike_writeback_if #(
  parameter int WIDTH     = 8,
  parameter int OUT_ROWS  = 3,
  parameter int OUT_COLS  = 3,
  parameter int TIMESTEPS = 2
);
  localparam int RW = OUT_ROWS > 1 ? $clog2(OUT_ROWS) : 1;
  localparam int TW = TIMESTEPS > 1 ? $clog2(TIMESTEPS) : 1;
  logic in_valid;
  logic in_ready;
  logic [WIDTH:0] in_data;
  logic mp_valid;
  logic mp_ready;
  logic [WIDTH+1:0] mp_data;
  logic spk_valid;
  logic spk_ready;
  logic [OUT_COLS-1:0] spk_data;
  logic [RW-1:0] spk_row;
  logic [TW-1:0] spk_ts;
  logic done;
  modport master (
    input  in_valid, in_data, mp_ready, spk_ready,
    output in_ready, mp_valid, mp_data, spk_valid, spk_data, spk_row, spk_ts, done
  );
  modport slave (
    output in_valid, in_data, mp_ready, spk_ready,
    input  in_ready, mp_valid, mp_data, spk_valid, spk_data, spk_row, spk_ts, done
  );
endinterface

// File: rtl/spike_writeback.sv
// spike_writeback: stores residual potentials, packs spikes into row words, feeds potentials back from ts 1 on.
//  clk    rising-edge clock
//  reset  asynchronous active-high reset
//  bus    spike_writeback_if.master: result input, potential feedback output, spike word output, done
module spike_writeback #(
  parameter int WIDTH     = 8,
  parameter int OUT_ROWS  = 3,
  parameter int OUT_COLS  = 3,
  parameter int TIMESTEPS = 2
) (
  input logic clk,
  input logic reset,
  spike_writeback_if.master bus
);
  localparam int RW = OUT_ROWS > 1 ? $clog2(OUT_ROWS) : 1;
  localparam int TW = TIMESTEPS > 1 ? $clog2(TIMESTEPS) : 1;
  localparam int CW = OUT_COLS > 1 ? $clog2(OUT_COLS) : 1;
  localparam int N  = OUT_ROWS * OUT_COLS;
  localparam int PW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [2:0] {IDLE, FEED, WAIT_RES, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] ts_q, ts_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [OUT_COLS-1:0] row_buf_q, row_buf_d;
  logic [WIDTH-1:0] pot_mem_q [N];
  logic [WIDTH+1:0] mp_data_q;
  logic in_ready_q, mp_valid_q, spk_valid_q, done_q;
  logic accept;
  logic [PW-1:0] pos, pos_next;
  assign pos = PW'(row_q * OUT_COLS + col_q);
  assign pos_next = PW'(row_d * OUT_COLS + col_d);
  assign accept = state_q == WAIT_RES && bus.in_valid;
  always_comb begin
    state_d = state_q;
    ts_d = ts_q;
    row_d = row_q;
    col_d = col_q;
    row_buf_d = row_buf_q;
    case (state_q)
      IDLE: state_d = ts_q != '0 ? FEED : WAIT_RES;
      FEED: if (bus.mp_ready) state_d = WAIT_RES;
      WAIT_RES:
        if (bus.in_valid) begin
          row_buf_d[col_q] = bus.in_data[WIDTH];
          if (col_q == CW'(OUT_COLS - 1)) begin
            col_d = '0;
            state_d = EMIT;
          end else begin
            col_d = col_q + 1'b1;
            state_d = ts_q != '0 ? FEED : WAIT_RES;
          end
        end
      EMIT:
        if (bus.spk_ready) begin
          row_buf_d = '0;
          if (row_q == RW'(OUT_ROWS - 1)) begin
            row_d = '0;
            if (ts_q == TW'(TIMESTEPS - 1)) state_d = DONE;
            else begin
              ts_d = ts_q + 1'b1;
              state_d = FEED;
            end
          end else begin
            row_d = row_q + 1'b1;
            state_d = ts_q != '0 ? FEED : WAIT_RES;
          end
        end
      default: ;
    endcase
  end
  // Handshake outputs are registered from the next state so they line up with the state they belong to;
  // mp_data is fetched for the position the next FEED will serve.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ts_q <= '0;
      row_q <= '0;
      col_q <= '0;
      row_buf_q <= '0;
      for (int i = 0; i < N; i++) pot_mem_q[i] <= '0;
      mp_data_q <= '0;
      in_ready_q <= 1'b0;
      mp_valid_q <= 1'b0;
      spk_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q <= ts_d;
      row_q <= row_d;
      col_q <= col_d;
      row_buf_q <= row_buf_d;
      if (accept) pot_mem_q[pos] <= bus.in_data[WIDTH-1:0];
      mp_data_q <= {2'b00, pot_mem_q[pos_next]};
      in_ready_q <= state_d == WAIT_RES;
      mp_valid_q <= state_d == FEED;
      spk_valid_q <= state_d == EMIT;
      done_q <= state_d == DONE;
    end
  assign bus.in_ready = in_ready_q;
  assign bus.mp_valid = mp_valid_q;
  assign bus.mp_data = mp_data_q;
  assign bus.spk_valid = spk_valid_q;
  assign bus.spk_data = row_buf_q;
  assign bus.spk_row = row_q;
  assign bus.spk_ts = ts_q;
  assign bus.done = done_q;
endmodule
